// File: rtl/tbu_pkg.sv
// Shared types and elaboration helpers for the Viterbi traceback unit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tbu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MERGE  = 2'd1,
        DECODE = 2'd2
    } tbu_state_e;

    // Widest state register supported (K = 9).
    localparam int TBU_MAX_M = 8;

    function automatic int tbu_m(input int k);
        return k - 1;
    endfunction

    function automatic int tbu_ns(input int k);
        return 1 << (k - 1);
    endfunction

    function automatic int tbu_cnt_w(input int win_len);
        return $clog2(win_len + 1);
    endfunction

    // Predecessor state: shift the survivor bit in at the LSB, dropping the
    // oldest state bit. Computed at the widest size and masked to m bits.
    function automatic logic [TBU_MAX_M-1:0] tbu_pred(
        input logic [TBU_MAX_M-1:0] state,
        input logic                 b,
        input int                   m
    );
        logic [TBU_MAX_M-1:0] p;
        p = {state[TBU_MAX_M-2:0], b};
        for (int i = 0; i < TBU_MAX_M; i++) begin
            if (i >= m) begin
                p[i] = 1'b0;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tbu_bank_mux.sv
// Picks the survivor decision bit of one trellis state from one of two banks.
// Latency: combinational.
// Backpressure: none.
// Ports: sel (bank select), bank0/bank1 (NS decision bits, bit s = state s),
//        idx (state index), bit_o (selected decision bit).
module tbu_bank_mux #(
    parameter int M = 3
) (
    input  logic               sel,
    input  logic [(1<<M)-1:0]  bank0,
    input  logic [(1<<M)-1:0]  bank1,
    input  logic [M-1:0]       idx,
    output logic               bit_o
);

    assign bit_o = sel ? bank1[idx] : bank0[idx];

endmodule

// File: rtl/tbu_param.sv
// Viterbi traceback: walks survivor decisions backwards, discards TB_DEPTH merge steps, emits decoded bits.
// Latency: first wr_en TB_DEPTH+2 cycles after the restart cycle; outputs registered once.
// Backpressure: none; output strobes are fire-and-forget, a restart mid-window aborts with overrun.
// Ports: clk, rst (async active-low), enable, selection (bank select + restart strobe),
//        d_in_0/d_in_1 (decision banks), use_best/best_state (start state),
//        d_o/wr_en (decoded bit + strobe), done (window complete), overrun (window aborted).
module tbu_param
    import tbu_pkg::*;
#(
    parameter int K         = 4,
    parameter int TB_DEPTH  = 4,
    parameter int WIN_LEN   = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 selection,
    input  logic [tbu_ns(K)-1:0] d_in_0,
    input  logic [tbu_ns(K)-1:0] d_in_1,
    input  logic                 use_best,
    input  logic [tbu_m(K)-1:0]  best_state,
    output logic                 d_o,
    output logic                 wr_en,
    output logic                 done,
    output logic                 overrun
);

    localparam int M  = tbu_m(K);
    localparam int CW = tbu_cnt_w(WIN_LEN);

    localparam logic [CW-1:0] CNT_ONE        = CW'(1);
    localparam logic [CW-1:0] CNT_MERGE_LAST = CW'(TB_DEPTH - 1);
    localparam logic [CW-1:0] CNT_WIN_LAST   = CW'(WIN_LEN - 1);

    tbu_state_e      state_q, state_d;
    logic [M-1:0]    pstate_q, pstate_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_q;

    logic            d_o_q, wr_en_q, done_q, overrun_q;
    logic            d_o_reg, wr_en_reg, done_reg, overrun_reg;

    logic            dec_bit;
    logic            sel_edge;
    logic            restart;
    logic [M-1:0]    pred_state;

    tbu_bank_mux #(
        .M (M)
    ) u_bank_mux (
        .sel   (selection),
        .bank0 (d_in_0),
        .bank1 (d_in_1),
        .idx   (pstate_q),
        .bit_o (dec_bit)
    );

    // Mode 0 restarts only on a falling selection edge; mode 1 on either edge.
    assign sel_edge   = (EDGE_MODE != 0) ? (sel_q != selection) : (sel_q & ~selection);
    assign restart    = enable & sel_edge;
    assign pred_state = M'(tbu_pred(TBU_MAX_M'(pstate_q), dec_bit, M));

    always_comb begin
        state_d     = state_q;
        pstate_d    = pstate_q;
        cnt_d       = cnt_q;
        d_o_reg     = 1'b0;
        wr_en_reg   = 1'b0;
        done_reg    = 1'b0;
        overrun_reg = 1'b0;

        if (!enable) begin
            state_d  = IDLE;
            pstate_d = '0;
            cnt_d    = '0;
        end else if (restart) begin
            state_d     = MERGE;
            pstate_d    = use_best ? best_state : '0;
            cnt_d       = '0;
            // Any window still in flight is abandoned.
            overrun_reg = (state_q != IDLE);
        end else begin
            unique case (state_q)
                MERGE: begin
                    pstate_d = pred_state;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_MERGE_LAST) begin
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    // Decoded bit is the MSB of the state before stepping back.
                    wr_en_reg = 1'b1;
                    d_o_reg   = pstate_q[M-1];
                    pstate_d  = pred_state;
                    cnt_d     = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_WIN_LAST) begin
                        done_reg = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pstate_q  <= '0;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            d_o_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pstate_q  <= pstate_d;
            cnt_q     <= cnt_d;
            sel_q     <= selection;
            d_o_q     <= d_o_reg;
            wr_en_q   <= wr_en_reg;
            done_q    <= done_reg;
            overrun_q <= overrun_reg;
        end
    end

    assign d_o     = d_o_q;
    assign wr_en   = wr_en_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_tbu_param.sv
// Testbench for tbu_param: two instances (falling-edge and any-edge restart) share
// all inputs and are checked every cycle against a window-level behavioural model.
module tb_tbu_param;

    localparam int K   = 4;
    localparam int TBD = 4;
    localparam int WL  = 8;
    localparam int M   = K - 1;
    localparam int NS  = 1 << M;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          selection = 1'b0;
    logic [NS-1:0] d_in_0 = '0;
    logic [NS-1:0] d_in_1 = '0;
    logic          use_best = 1'b0;
    logic [M-1:0]  best_state = '0;

    logic d_o0, wr_en0, done0, overrun0;
    logic d_o1, wr_en1, done1, overrun1;

    always #5 clk = ~clk;

    tbu_param #(.K(K), .TB_DEPTH(TBD), .WIN_LEN(WL), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .selection(selection),
        .d_in_0(d_in_0), .d_in_1(d_in_1), .use_best(use_best), .best_state(best_state),
        .d_o(d_o0), .wr_en(wr_en0), .done(done0), .overrun(overrun0)
    );

    tbu_param #(.K(K), .TB_DEPTH(TBD), .WIN_LEN(WL), .EDGE_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .selection(selection),
        .d_in_0(d_in_0), .d_in_1(d_in_1), .use_best(use_best), .best_state(best_state),
        .d_o(d_o1), .wr_en(wr_en1), .done(done1), .overrun(overrun1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: a window is a step index (-1 = no window) plus the current trellis state.
    int   step_m[2];
    int   ps_m[2];
    logic e_wr[2], e_do[2], e_dn[2], e_ov[2];
    logic o_wr[2], o_do[2], o_dn[2], o_ov[2];
    logic sel_prev = 1'b0;

    int c_wr[2], c_one[2], c_dn[2], c_ov[2], first_wr[2];
    int cyc;

    task automatic clr_cnt();
        for (int i = 0; i < 2; i++) begin
            c_wr[i] = 0; c_one[i] = 0; c_dn[i] = 0; c_ov[i] = 0; first_wr[i] = -1;
        end
        cyc = 0;
    endtask

    // Evaluate the model for the current inputs, clock once, then compare.
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            logic rs;
            int   bv;
            e_wr[i] = 1'b0; e_do[i] = 1'b0; e_dn[i] = 1'b0; e_ov[i] = 1'b0;
            rs = (i == 1) ? (sel_prev != selection) : (sel_prev && !selection);
            if (!rst || !enable) begin
                step_m[i] = -1;
                ps_m[i]   = 0;
            end else if (rs) begin
                e_ov[i]   = (step_m[i] >= 0);
                step_m[i] = 0;
                ps_m[i]   = use_best ? int'(best_state) : 0;
            end else if (step_m[i] >= 0) begin
                bv = selection ? int'(d_in_1[ps_m[i]]) : int'(d_in_0[ps_m[i]]);
                if (step_m[i] >= TBD) begin
                    e_wr[i] = 1'b1;
                    e_do[i] = (ps_m[i] >= NS / 2);
                end
                ps_m[i] = (2 * ps_m[i] + bv) % NS;
                step_m[i]++;
                if (step_m[i] == WL) begin
                    e_dn[i]   = 1'b1;
                    step_m[i] = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        sel_prev = rst ? selection : 1'b0;
        cyc++;
        o_wr[0] = wr_en0; o_do[0] = d_o0; o_dn[0] = done0; o_ov[0] = overrun0;
        o_wr[1] = wr_en1; o_do[1] = d_o1; o_dn[1] = done1; o_ov[1] = overrun1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wr_en[%0d]", i),   o_wr[i], e_wr[i]);
            chk($sformatf("d_o[%0d]", i),     o_do[i], e_do[i]);
            chk($sformatf("done[%0d]", i),    o_dn[i], e_dn[i]);
            chk($sformatf("overrun[%0d]", i), o_ov[i], e_ov[i]);
            if (o_wr[i] === 1'b1) begin
                c_wr[i]++;
                if (first_wr[i] < 0) first_wr[i] = cyc;
                if (o_do[i] === 1'b1) c_one[i]++;
            end
            if (o_dn[i] === 1'b1) c_dn[i]++;
            if (o_ov[i] === 1'b1) c_ov[i]++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            step_m[i] = -1;
            ps_m[i]   = 0;
        end
        clr_cnt();

        // Reset state
        repeat (3) step();
        rst = 1'b1;
        enable = 1'b1;
        selection = 1'b1;
        repeat (2) step();

        // 1: zero decisions, falling edge, start at state 0
        selection = 1'b0;
        clr_cnt();
        repeat (12) step();
        chk("t1_wr_cnt", c_wr[0], 4);
        chk("t1_first_wr", first_wr[0], TBD + 2);
        chk("t1_ones", c_one[0], 0);
        chk("t1_done", c_dn[0], 1);

        // 2: all-ones bank 0 drives state to 7, decoded bits 1
        d_in_0 = 8'hFF;
        selection = 1'b1;
        step();
        selection = 1'b0;
        clr_cnt();
        repeat (12) step();
        chk("t2_wr_cnt", c_wr[0], 4);
        chk("t2_ones", c_one[0], 4);
        chk("t2_done", c_dn[0], 1);

        // 3: rising edge restarts only the any-edge instance, from best_state, on bank 1
        d_in_1 = 8'h00;
        use_best = 1'b1;
        best_state = 3'b101;
        selection = 1'b1;
        clr_cnt();
        repeat (12) step();
        chk("t3_wr_cnt1", c_wr[1], 4);
        chk("t3_ones1", c_one[1], 0);
        chk("t3_done1", c_dn[1], 1);
        chk("t3_wr_cnt0", c_wr[0], 0);
        use_best = 1'b0;

        // 4: restart lands on the final decode step of the window
        d_in_0 = NS'($urandom);
        d_in_1 = NS'($urandom);
        selection = 1'b0;
        clr_cnt();
        repeat (7) step();
        selection = 1'b1;
        step();
        selection = 1'b0;
        step();
        repeat (12) step();
        chk("t4_overrun", c_ov[0], 1);
        chk("t4_done", c_dn[0], 1);
        chk("t4_wr_cnt", c_wr[0], 7);

        // 5: rising edge mid-window ignored by falling-edge instance, then enable drop
        selection = 1'b1;
        step();
        selection = 1'b0;
        clr_cnt();
        repeat (3) step();
        selection = 1'b1;
        repeat (10) step();
        chk("t5_wr_cnt", c_wr[0], 4);
        chk("t5_done", c_dn[0], 1);
        chk("t5_overrun", c_ov[0], 0);
        selection = 1'b0;
        clr_cnt();
        repeat (6) step();
        enable = 1'b0;
        repeat (4) step();
        chk("t5_en_wr_cnt", c_wr[0], 1);
        chk("t5_en_done", c_dn[0], 0);
        enable = 1'b1;
        step();

        // 6: asynchronous reset during decode
        selection = 1'b1;
        step();
        selection = 1'b0;
        clr_cnt();
        repeat (7) step();
        chk("t6_pre_wr", wr_en0, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_wr", wr_en0, 0);
        chk("t6_rst_do", d_o0, 0);
        chk("t6_rst_done", done0, 0);
        chk("t6_rst_ovr", overrun0, 0);
        repeat (2) step();
        rst = 1'b1;
        clr_cnt();
        repeat (10) step();
        chk("t6_idle_wr0", c_wr[0], 0);
        chk("t6_idle_wr1", c_wr[1], 0);
        selection = 1'b1;
        step();
        selection = 1'b0;
        clr_cnt();
        repeat (12) step();
        chk("t6_after_wr", c_wr[0], 4);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            enable = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 11) == 0) selection = ~selection;
            d_in_0 = NS'($urandom);
            d_in_1 = NS'($urandom);
            use_best = 1'($urandom_range(0, 1));
            best_state = M'($urandom_range(0, NS - 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
